// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the icache and loads the IF/ID register.
// Latency: instruction at icache_addr is visible on if_id_* one edge later; redirect adds one bubble.
// Backpressure: id_ready=0 with a live IF/ID entry freezes pc and if_id_*; redirect still wins.
//
// Ports:
//   clock, reset            single rising-edge clock; asynchronous active-low reset
//   icache_addr             byte address to the icache (always equal to pc)
//   icache_instr            combinational instruction word returned for icache_addr
//   redirect_valid/target   PC change request from EX (target bits [1:0] dropped)
//   halt_req                stop fetching after this cycle (honoured only in RUN)
//   id_ready                decode accepts the IF/ID entry this cycle
//   if_id_valid/pc/instr    IF/ID pipeline register
//   halted                  high while fetch is parked in HALT
//   fetch_count             saturating count of instructions loaded into IF/ID
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic [31:0]      icache_addr,
  input  logic [31:0]      icache_instr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             halt_req,
  input  logic             id_ready,
  output logic             if_id_valid,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;

  logic        redirect_take;
  logic        advance;
  logic        drain;
  logic        cnt_sat;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  assign icache_addr    = pc;
  assign pc_plus4       = pc + 32'd4;   // wraps modulo 2^32 by construction
  assign target_aligned = {redirect_target[31:2], 2'b00};
  assign cnt_sat        = (fetch_count == {CNT_W{1'b1}});

  // Datapath actions for this edge. BOOT does nothing but burn one cycle, so the
  // first instruction is captured on the second edge after reset release.
  always_comb begin
    redirect_take = 1'b0;
    advance       = 1'b0;
    drain         = 1'b0;
    case (state)
      ST_RUN: begin
        redirect_take = redirect_valid;
        // An empty IF/ID slot can always be filled, regardless of id_ready.
        advance       = !redirect_valid && (id_ready || !if_id_valid);
      end
      ST_HALT: begin
        redirect_take = redirect_valid;
        // Decode may still consume the last captured instruction while parked.
        drain         = !redirect_valid && id_ready;
      end
      default: begin
      end
    endcase
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic. A redirect in the same cycle as halt_req keeps us running.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN:  if (halt_req && !redirect_valid) state_nxt = ST_HALT;
      ST_HALT: if (redirect_valid) state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    halted = (state == ST_HALT);
  end

  // PC, IF/ID register and fetch counter
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc    <= 32'h0;
      if_id_instr <= 32'h0;
      fetch_count <= '0;
    end else if (redirect_take) begin
      // Flush: the stale IF/ID entry (even a stalled one) is dropped, pc/instr left as is.
      pc          <= target_aligned;
      if_id_valid <= 1'b0;
    end else if (advance) begin
      pc          <= pc_plus4;
      if_id_valid <= 1'b1;
      if_id_pc    <= pc;
      if_id_instr <= icache_instr;
      if (!cnt_sat) begin
        fetch_count <= fetch_count + CNT_ONE;
      end
    end else if (drain) begin
      if_id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random traffic,
// all compared every cycle against a behavioural model of the fetch stage.
module tb_fetch_unit;

  localparam int CNT_W   = 6;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clock;
  logic             reset;
  logic [31:0]      icache_addr;
  logic [31:0]      icache_instr;
  logic             redirect_valid;
  logic [31:0]      redirect_target;
  logic             halt_req;
  logic             id_ready;
  logic             if_id_valid;
  logic [31:0]      if_id_pc;
  logic [31:0]      if_id_instr;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .icache_addr    (icache_addr),
    .icache_instr   (icache_instr),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .id_ready       (id_ready),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: a fixed scrambling of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  always_comb icache_instr = mem_word(icache_addr);

  // Reference model: "booting" / "halted" flags, the PC, the IF/ID contents, the count.
  bit          m_booting;
  bit          m_halted;
  logic [31:0] m_pc;
  bit          m_v;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifi;
  int          m_cnt;

  task automatic model_reset();
    m_booting = 1'b1;
    m_halted  = 1'b0;
    m_pc      = 32'h0;
    m_v       = 1'b0;
    m_ifpc    = 32'h0;
    m_ifi     = 32'h0;
    m_cnt     = 0;
  endtask

  // One rising edge of the fetch stage, using the inputs currently applied.
  task automatic model_edge();
    if (!reset) return;
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (redirect_valid) begin
      m_pc     = redirect_target & ~32'h3;
      m_v      = 1'b0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      if (id_ready) m_v = 1'b0;
    end else begin
      if (id_ready || !m_v) begin
        m_ifi  = mem_word(m_pc);
        m_ifpc = m_pc;
        m_v    = 1'b1;
        m_pc   = m_pc + 32'd4;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      if (halt_req) m_halted = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic compare_all(input string ph);
    chk({ph, ".icache_addr"}, icache_addr, m_pc);
    chk({ph, ".if_id_valid"}, 32'(if_id_valid), 32'(m_v));
    chk({ph, ".if_id_pc"}, if_id_pc, m_ifpc);
    chk({ph, ".if_id_instr"}, if_id_instr, m_ifi);
    chk({ph, ".halted"}, 32'(halted), 32'(m_halted));
    chk({ph, ".fetch_count"}, 32'(fetch_count), 32'(m_cnt));
  endtask

  // Inputs are changed 1 time unit after a rising edge and sampled there too.
  task automatic step(input string ph);
    model_edge();
    @(posedge clock);
    #1;
    compare_all(ph);
  endtask

  task automatic set_in(input bit rv, input logic [31:0] tgt, input bit hr, input bit rdy);
    redirect_valid  = rv;
    redirect_target = tgt;
    halt_req        = hr;
    id_ready        = rdy;
  endtask

  initial begin
    reset = 1'b0;
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    #1;
    model_reset();
    compare_all("reset");
    repeat (2) step("in_reset");
    reset = 1'b1;

    // T1: boot bubble, then sequential fetch
    step("t1_boot");
    chk("t1_boot_valid", 32'(if_id_valid), 32'h0);
    step("t1_first");
    chk("t1_first_addr", icache_addr, 32'h4);
    chk("t1_first_pc", if_id_pc, 32'h0);
    repeat (4) step("t1_run");
    chk("t1_pc10", if_id_pc, 32'h10);
    chk("t1_count", 32'(fetch_count), 32'd5);

    // T2: stall freezes pc and IF/ID
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) step("t2_stall");
    chk("t2_held_pc", if_id_pc, 32'h10);
    chk("t2_held_addr", icache_addr, 32'h14);
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    step("t2_release");
    chk("t2_next_pc", if_id_pc, 32'h14);

    // T3: redirect with misaligned target
    set_in(1'b1, 32'h15, 1'b0, 1'b1);
    step("t3_redir");
    chk("t3_addr", icache_addr, 32'h14);
    chk("t3_flush", 32'(if_id_valid), 32'h0);
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    step("t3_after");
    chk("t3_target_pc", if_id_pc, 32'h14);

    // T4: redirect + stall + halt together
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    step("t4_stall");
    set_in(1'b1, 32'h100, 1'b1, 1'b0);
    step("t4_all");
    chk("t4_halted", 32'(halted), 32'h0);
    chk("t4_flush", 32'(if_id_valid), 32'h0);
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    step("t4_after");

    // T5: halt, drain, resume via redirect
    set_in(1'b1, 32'h20, 1'b0, 1'b1);
    step("t5_goto20");
    set_in(1'b0, 32'h0, 1'b1, 1'b1);
    step("t5_halt");
    chk("t5_cap_pc", if_id_pc, 32'h20);
    chk("t5_halted", 32'(halted), 32'h1);
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    step("t5_drain");
    chk("t5_drained", 32'(if_id_valid), 32'h0);
    step("t5_park");
    chk("t5_pc_held", icache_addr, 32'h24);
    set_in(1'b1, 32'h4, 1'b0, 1'b1);
    step("t5_resume");
    chk("t5_resumed", 32'(halted), 32'h0);
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    step("t5_fetch4");
    chk("t5_pc4", if_id_pc, 32'h4);

    // T6: PC wrap, then asynchronous reset during a stall
    set_in(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step("t6_redir");
    set_in(1'b0, 32'h0, 1'b0, 1'b1);
    step("t6_top");
    chk("t6_top_pc", if_id_pc, 32'hFFFF_FFFC);
    step("t6_wrap");
    chk("t6_wrap_pc", if_id_pc, 32'h0);
    set_in(1'b0, 32'h0, 1'b0, 1'b0);
    step("t6_stall");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("t6_async_rst");
    step("t6_in_reset");
    reset = 1'b1;
    set_in(1'b0, 32'h0, 1'b0, 1'b1);

    // Counter saturation
    repeat (CNT_MAX + 8) step("sat");
    chk("sat_count", 32'(fetch_count), 32'(CNT_MAX));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 15) == 0,
             $urandom_range(0, 3) != 0);
      if (i == 300) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("rnd_rst");
        step("rnd_in_reset");
        reset = 1'b1;
      end else begin
        step("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
